// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and the default width.
package sub_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Signed overflow of a subtraction: operands of opposite sign and a result whose sign left the minuend's.
    function automatic logic subOverflow(input logic aSign, input logic bSign, input logic dSign);
        return (aSign != bSign) && (dSign != aSign);
    endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Start/done handshake and operand/result bundle between a controller (master) and the subtractor (slave).
interface sub_serial_if #(parameter int WIDTH = sub_serial_pkg::DEFAULT_WIDTH) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, b_in,
        input  diff, b_out, ovf, busy, done
    );

    modport slave (
        input  start, a, b, b_in,
        output diff, b_out, ovf, busy, done
    );

endinterface

// File: rtl/sub_serial_fs_vr.sv
// Combinational one-bit full subtractor: diff = a - b - b_in with borrow out.
module fs_vr (
    output logic diff,
    output logic b_out,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first, one bit per clock,
// with a start/done handshake and results held stable between operations.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    sub_serial_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-2:0] r_diffSh;
    logic             r_borrow;
    logic             r_aSign;
    logic             r_bSign;
    logic [WIDTH-1:0] r_diff;
    logic             r_bOut;
    logic             r_ovf;

    logic             w_d;
    logic             w_br;
    logic             w_last;
    logic [WIDTH-1:0] w_diffNext;

    fs_vr u_fs (
        .diff  (w_d),
        .b_out (w_br),
        .a     (r_aSh[0]),
        .b     (r_bSh[0]),
        .b_in  (r_borrow)
    );

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_diffNext = {w_d, r_diffSh};

    // Partial result enters from the MSB side, so after WIDTH bits it lines up without a final shift.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_aSh    <= '0;
            r_bSh    <= '0;
            r_diffSh <= '0;
            r_borrow <= 1'b0;
            r_aSign  <= 1'b0;
            r_bSign  <= 1'b0;
            r_diff   <= '0;
            r_bOut   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_aSh    <= r_aSh >> 1;
                    r_bSh    <= r_bSh >> 1;
                    r_diffSh <= w_diffNext[WIDTH-1:1];
                    r_borrow <= w_br;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_diff  <= w_diffNext;
                        r_bOut  <= w_br;
                        r_ovf   <= subOverflow(r_aSign, r_bSign, w_d);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, giving back-to-back operation from DONE.
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_aSh    <= bus.a;
                        r_bSh    <= bus.b;
                        r_diffSh <= '0;
                        r_borrow <= bus.b_in;
                        r_aSign  <= bus.a[WIDTH-1];
                        r_bSign  <= bus.b[WIDTH-1];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.diff  = r_diff;
    assign bus.b_out = r_bOut;
    assign bus.ovf   = r_ovf;
    assign bus.busy  = (r_state == S_RUN);
    assign bus.done  = (r_state == S_DONE);

endmodule
